// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO: start, D0..D7 LSB first, parity, stop.
// Bit boundaries are rising edges of CLK_Baud detected in the CLK domain.
module uart_tx_fifo #(
    parameter int FIFO_AW    = 2,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CLK_Baud,
    input  logic       WR_EN,
    input  logic [7:0] WR_Data,
    output logic       FIFO_Full,
    output logic       FIFO_Empty,
    output logic       TX_Busy,
    output logic       Serial_output
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count, count_next;
    logic               baud_prev, baud_tick, push, pop;

    state_t     state, state_next;
    logic [7:0] shreg, shreg_next;
    logic [3:0] cnt, cnt_next;
    logic       par, par_next, line_next;

    assign baud_tick = CLK_Baud & ~baud_prev;
    assign push      = WR_EN & ~FIFO_Full;
    assign TX_Busy   = (state != IDLE);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_ONE;
        else if (pop && !push)
            count_next = count - CNT_ONE;
    end

    // Storage needs no reset; only pointers and count define its contents.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= WR_Data;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            FIFO_Full  <= 1'b0;
            FIFO_Empty <= 1'b1;
            baud_prev  <= 1'b1;
        end else begin
            baud_prev  <= CLK_Baud;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count      <= count_next;
            FIFO_Full  <= (count_next == CNT_FULL);
            FIFO_Empty <= (count_next == '0);
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state         <= IDLE;
            shreg         <= '0;
            cnt           <= '0;
            par           <= 1'b0;
            Serial_output <= 1'b1;
        end else begin
            state         <= state_next;
            shreg         <= shreg_next;
            cnt           <= cnt_next;
            par           <= par_next;
            Serial_output <= line_next;
        end
    end

    // State names the bit currently on the line; everything moves on baud_tick only.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        par_next   = par;
        line_next  = Serial_output;
        pop        = 1'b0;
        if (baud_tick) begin
            case (state)
                IDLE, STOP: begin
                    if (!FIFO_Empty) begin
                        pop        = 1'b1;
                        shreg_next = mem[rd_ptr];
                        par_next   = 1'b0;
                        line_next  = 1'b0;
                        state_next = START;
                    end else begin
                        line_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
                START: begin
                    line_next  = shreg[0];
                    par_next   = par ^ shreg[0];
                    shreg_next = {1'b0, shreg[7:1]};
                    cnt_next   = 4'd1;
                    state_next = DATA;
                end
                DATA: begin
                    if (cnt < 4'd8) begin
                        line_next  = shreg[0];
                        par_next   = par ^ shreg[0];
                        shreg_next = {1'b0, shreg[7:1]};
                        cnt_next   = cnt + 4'd1;
                    end else begin
                        line_next  = par ^ PARITY_ODD;
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    line_next  = 1'b1;
                    state_next = STOP;
                end
                default: begin
                    line_next  = 1'b1;
                    state_next = IDLE;
                end
            endcase
        end
    end
endmodule
